// File: rtl/instr_encoder.sv
// instr_encoder
// Streaming RV32 instruction encoder. It takes a decoded instruction
// description, packs it into a 32-bit instruction word and range/alignment
// checks the immediate. Each word is tagged with a sequential byte address
// so it can be written straight into instruction memory.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake
//   in_fmt               0=I 1=S 2=B 3=U 4=J, 5-7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm
//                        decoded fields; in_imm is the full signed value
//   out_valid / out_ready  result handshake
//   out_instr            encoded word (zero when the request was illegal)
//   out_addr             byte address assigned to this word
//   out_err              request was illegal
//   err_cnt              saturating count of accepted illegal requests
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  logic              outValid_q;
  logic [31:0]       outInstr_q;
  logic [ADDR_W-1:0] outAddr_q;
  logic              outErr_q;
  logic [ADDR_W-1:0] addrCnt_q;
  logic [7:0]        errCnt_q;

  logic [31:0]       encWord;
  logic              immLegal;
  logic [31:0]       instr_d;
  logic [7:0]        errCnt_d;
  logic              accept;

  // A signed value fits in N bits when every bit from N-1 upward equals the
  // sign bit, so the range checks reduce to "upper bits all ones or all zeros".
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  // Format-specific bit packing and legality of the immediate.
  always_comb begin
    encWord  = 32'h0;
    immLegal = 1'b0;
    case (in_fmt)
      FMT_I: begin
        encWord  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        immLegal = fits12;
      end
      FMT_S: begin
        encWord  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        immLegal = fits12;
      end
      FMT_B: begin
        encWord  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        immLegal = fits13 && !in_imm[0];
      end
      FMT_U: begin
        encWord  = {in_imm[31:12], in_rd, in_opcode};
        immLegal = (in_imm[11:0] == 12'h0);
      end
      FMT_J: begin
        encWord  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        immLegal = fits21 && !in_imm[0];
      end
      default: begin
        encWord  = 32'h0;
        immLegal = 1'b0;
      end
    endcase
  end

  // Illegal requests still produce a word (all zeros) so the address stream
  // stays dense and the consumer sees the error in order.
  always_comb begin
    instr_d  = immLegal ? encWord : 32'h0;
    errCnt_d = errCnt_q;
    if (accept && !immLegal && (errCnt_q != 8'hFF)) begin
      errCnt_d = errCnt_q + 8'd1;
    end
  end

  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single output stage: a new word loads whenever a request is accepted,
  // which also covers the same-cycle drain-and-refill case. Without a new
  // request a completed handshake only drops valid; data fields keep their
  // last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outInstr_q <= 32'h0;
      outAddr_q  <= '0;
      outErr_q   <= 1'b0;
      addrCnt_q  <= BASE_ADDR;
      errCnt_q   <= 8'h0;
    end else begin
      errCnt_q <= errCnt_d;
      if (accept) begin
        outValid_q <= 1'b1;
        outInstr_q <= instr_d;
        outAddr_q  <= addrCnt_q;
        outErr_q   <= !immLegal;
        addrCnt_q  <= addrCnt_q + ADDR_W'(4);
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_instr = outInstr_q;
  assign out_addr  = outAddr_q;
  assign out_err   = outErr_q;
  assign err_cnt   = errCnt_q;

endmodule
